// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with bounded hold time.
// IDLE searches circularly from ptr for the first active request and grants it.
// GRANT holds the owner until it is disabled, released, drops its request, or
// runs out of hold time. RELEASE is a one-cycle gap before re-arbitration.
// The pointer advances past each owner, so no requester can be starved.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Value of hold_cnt in the last cycle a grant may be held.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic       r_timeout;

    state_t     w_state_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_hold_nxt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_gnt_idx_nxt;
    logic       w_gnt_valid_nxt;
    logic       w_timeout_nxt;

    logic       w_found;
    logic [2:0] w_pick;
    logic       w_hold_expired;
    logic       w_exit;

    // Circular priority search: first set request at ptr, ptr+1, ..., ptr+7.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && req[r_ptr + 3'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 3'(k);
            end
        end
    end

    // Exit terms for the current grant; timeout only when expiry is the sole cause.
    always_comb begin
        w_hold_expired = (r_hold_cnt == HOLD_LAST);
        w_exit         = !En || done || !req[r_gnt_idx] || w_hold_expired;
    end

    // Next-state and next-output logic; registers hold unless a state changes them.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (En && w_found) begin
                    w_gnt_idx_nxt   = w_pick;
                    w_gnt_nxt       = 8'h01 << w_pick;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = 8'd0;
                    w_state_nxt     = GRANT;
                end else begin
                    w_gnt_nxt       = 8'h00;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_exit) begin
                    w_gnt_nxt       = 8'h00;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 3'd1;
                    w_state_nxt     = RELEASE;
                    w_timeout_nxt   = En && !done && req[r_gnt_idx] && w_hold_expired;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = 8'h00;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational logic.
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 (instantiated with MAX_HOLD=4).
// Inputs change 1 ns after each rising edge; outputs are sampled at that point.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       En;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (En),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever fails to finish.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        En    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        En    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
        checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", gnt_idx); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        En  = 1'b1;
        req = 8'b0010_0100;
        tick();
        checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL basic_gnt: got %h expected 04", gnt); end
        checks++; if (gnt_idx !== 3'd2) begin errors++; $display("FAIL basic_idx: got %0d expected 2", gnt_idx); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", gnt_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL basic_release: got gnt %h valid %b expected 00/0", gnt, gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_release_to: got %b expected 0", timeout); end
        checks++; if (gnt_idx !== 3'd2) begin errors++; $display("FAIL basic_idx_hold: got %0d expected 2", gnt_idx); end
        tick();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL basic_gap: got %h expected 00", gnt); end
        tick();
        checks++; if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin errors++; $display("FAIL basic_next: got %h idx %0d expected 20 idx 5", gnt, gnt_idx); end
        req = 8'h00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [2:0] exp_idx;
        do_reset();
        En  = 1'b1;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            exp_idx = 3'(g % 8);
            tick();
            checks++; if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx || gnt !== (8'h01 << exp_idx))
                begin errors++; $display("FAIL fair_grant%0d: got %h idx %0d expected idx %0d", g, gnt, gnt_idx, exp_idx); end
            tick();
            checks++; if (gnt_idx !== exp_idx || gnt_valid !== 1'b1)
                begin errors++; $display("FAIL fair_hold%0d: got idx %0d valid %b expected idx %0d valid 1", g, gnt_idx, gnt_valid, exp_idx); end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL fair_gap1_%0d: got %h expected 00", g, gnt); end
            tick();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL fair_gap2_%0d: got %h expected 00", g, gnt); end
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        En  = 1'b1;
        req = 8'h20;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (gnt !== 8'h20 || timeout !== 1'b0)
                begin errors++; $display("FAIL to_hold%0d: got %h to %b expected 20 to 0", c, gnt, timeout); end
        end
        tick();
        checks++; if (gnt !== 8'h00 || timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %h to %b expected 00 to 1", gnt, timeout); end
        tick();
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL to_end: got %h to %b expected 00 to 0", gnt, timeout); end
        tick();
        checks++; if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin errors++; $display("FAIL to_regrant: got %h idx %0d expected 20 idx 5", gnt, gnt_idx); end
    endtask

    // Continues from the regrant to requester 5 left by test_timeout.
    task automatic test_simultaneous();
        tick();
        tick();
        tick();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL sim_last: got %h expected 20", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL sim_done: got %h to %b expected 00 to 0", gnt, timeout); end
        tick();
        tick();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL sim_regrant: got %h expected 20", gnt); end
        tick();
        En = 1'b0;
        tick();
        checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0)
            begin errors++; $display("FAIL sim_en_off: got %h valid %b to %b expected 00/0/0", gnt, gnt_valid, timeout); end
        tick();
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL sim_en_rel: got %h to %b expected 00 to 0", gnt, timeout); end
        done = 1'b1;
        tick();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL sim_en_idle: got %h expected 00", gnt); end
        done = 1'b0;
        req  = 8'h00;
    endtask

    task automatic test_req_drop();
        do_reset();
        En  = 1'b1;
        req = 8'h48;
        tick();
        checks++; if (gnt_idx !== 3'd3 || gnt !== 8'h08) begin errors++; $display("FAIL drop_grant: got %h idx %0d expected 08 idx 3", gnt, gnt_idx); end
        tick();
        req = 8'h44;
        tick();
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL drop_release: got %h to %b expected 00 to 0", gnt, timeout); end
        tick();
        tick();
        checks++; if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin errors++; $display("FAIL drop_next: got %h idx %0d expected 40 idx 6", gnt, gnt_idx); end
    endtask

    task automatic test_async_reset();
        do_reset();
        En  = 1'b1;
        req = 8'h10;
        tick();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL ar_grant: got %h expected 10", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0)
            begin errors++; $display("FAIL ar_clear: got %h idx %0d valid %b to %b expected all 0", gnt, gnt_idx, gnt_valid, timeout); end
        tick();
        checks++; if (timeout !== 1'b0 || gnt !== 8'h00) begin errors++; $display("FAIL ar_held: got %h to %b expected 00 to 0", gnt, timeout); end
        req   = 8'h80;
        rst_n = 1'b1;
        tick();
        checks++; if (gnt !== 8'h80 || gnt_idx !== 3'd7 || gnt_valid !== 1'b1)
            begin errors++; $display("FAIL ar_after: got %h idx %0d valid %b expected 80 idx 7 valid 1", gnt, gnt_idx, gnt_valid); end
        req = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_simultaneous();
        test_req_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum cycles one owner may hold a grant (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: En  input  1  arbiter enable; 0 blocks new grants and revokes any current grant.
REQ-005 Port: req  input  8  request lines, bit i = requester i.
REQ-006 Port: done  input  1  release strobe from the current owner.
REQ-007 Port: gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-008 Port: gnt_idx  output  3  registered binary index of the owner; gnt SHALL equal the 3-to-8 decode of gnt_idx whenever gnt_valid=1.
REQ-009 Port: gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-010 Port: timeout  output  1  registered one-cycle pulse marking a forced release.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and RELEASE, held in an internal state register with a 3-bit round-robin pointer ptr and an 8-bit hold counter hold_cnt.
REQ-012 IDLE: if En=1 and req!=0, search circularly ptr, ptr+1, ..., ptr+7 (mod 8), pick the first set bit, load gnt_idx, gnt and gnt_valid, clear hold_cnt, and go to GRANT at the same edge.
REQ-013 IDLE: if En=0 or req=0, remain in IDLE with gnt=0 and gnt_valid=0.
REQ-014 Grant latency: a request sampled at edge N in IDLE SHALL appear on gnt after edge N (visible in cycle N+1).
REQ-015 GRANT: hold_cnt SHALL increment by 1 each cycle; it is 0 in the first grant cycle.
REQ-016 GRANT exit conditions, in priority order: En=0; done=1; req[gnt_idx]=0; hold_cnt=MAX_HOLD-1.
REQ-017 On any GRANT exit, at that edge: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (7 wraps to 0), next state RELEASE; gnt_idx holds its last value.
REQ-018 timeout SHALL pulse 1 for the RELEASE cycle only when the exit is due solely to hold_cnt=MAX_HOLD-1 (En=1, done=0, req[gnt_idx]=1); otherwise it stays 0.
REQ-019 RELEASE SHALL last exactly one cycle and then go to IDLE unconditionally, so there are at least 2 cycles with gnt=0 between consecutive grants.
REQ-020 Requests arriving during GRANT or RELEASE SHALL have no effect until evaluated in IDLE; requests are not latched.
REQ-021 A grant SHALL last at most MAX_HOLD cycles.
REQ-022 With all requesters continuously requesting, each SHALL be granted once per 8 grants (no starvation).
REQ-023 done asserted outside GRANT SHALL be ignored.
REQ-024 At most one bit of gnt SHALL be set in any cycle.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
REQ-026 Reset asserted mid-grant SHALL drop gnt without passing through RELEASE, and SHALL NOT pulse timeout.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n=1, starting the search at ptr=0.

Verification
REQ-028 Basic grant: after reset, En=1, req=8'b0010_0100 at edge 3 -> gnt=8'h04, gnt_idx=2, gnt_valid=1 from cycle 4; done pulse -> gnt=0 next cycle, then ptr=3 and the next grant goes to requester 5 (gnt=8'h20).
REQ-029 Fairness: req=8'hFF held, done pulsed in each grant's second cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with a 2-cycle gnt=0 gap between grants.
REQ-030 Timeout: MAX_HOLD=4, only req[5]=1 held, done=0 -> gnt=8'h20 for exactly 4 cycles, timeout=1 for one cycle, then requester 5 is regranted after the search wraps from ptr=6.
REQ-031 Simultaneous events: done=1 in the same cycle that hold_cnt=MAX_HOLD-1 -> release occurs with timeout=0; En=0 mid-grant -> gnt=0 at the next edge, timeout=0.
REQ-032 Requester drop: owner 3 deasserts req[3] mid-grant while req[6]=1 -> release, ptr=4, next grant gnt=8'h40.
REQ-033 Async reset: rst_n pulled low between clock edges during GRANT -> all outputs are 0 before the next edge; after release, req=8'h80 is granted with gnt_idx=7.
